decoder_scan_ctrl: RTL

DECODER_SCAN_CTRL -- requirements
Module: decoder_scan_ctrl

---
 rtl/decoder_pkg.sv | 12 +
 rtl/scan_next_ch.sv | 13 +
 rtl/decoder_scan_ctrl.sv | 72 +++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// decoder_pkg: shared enable codes, channel count, scan FSM states and lowest-set-channel helper
package decoder_pkg;
  localparam logic [2:0] EN_ON = 3'b001;
  localparam logic [2:0] EN_OFF = 3'b000;
  localparam int NCH = 8;
  typedef enum logic [1:0] {IDLE, ACTIVE, GAP, DONE} state_t;
  function automatic logic [3:0] lowest_ch(input logic [NCH-1:0] m);
    lowest_ch = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (m[i]) lowest_ch = {1'b1, 3'(i)};
  endfunction
endpackage

// File: rtl/scan_next_ch.sv
// scan_next_ch: next scanned channel strictly above the current one, with found flag
module scan_next_ch
  import decoder_pkg::*;
(
  input  logic [NCH-1:0] mask,
  input  logic [2:0]     ch,
  output logic [2:0]     nxt,
  output logic           found
);
  logic [NCH-1:0] above;
  assign above = mask & ~((8'd2 << ch) - 8'd1);
  assign {found, nxt} = lowest_ch(above);
endmodule

// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl: break-before-make channel scanner for a 3-to-8 decoder; SCAN_MASK_EN adds the mask port
module decoder_scan_ctrl
  import decoder_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
`ifdef SCAN_MASK_EN
  input  logic [NCH-1:0]     mask,
`endif
  output logic [2:0]         En,
  output logic [2:0]         I,
  output logic               busy,
  output logic               done
);
  state_t state, state_d;
  logic [DWELL_W-1:0] dwell_q, cnt, dwell_m1;
  logic [2:0] first, nxt;
  logic any, nxt_found;
  assign dwell_m1 = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
`ifdef SCAN_MASK_EN
  logic [NCH-1:0] mask_q;
  assign {any, first} = lowest_ch(mask);
  scan_next_ch u_next (.mask(mask_q), .ch(I), .nxt(nxt), .found(nxt_found));
  always_ff @(posedge clk)
    if (rst) mask_q <= '0;
    else if (state == IDLE && state_d != IDLE) mask_q <= mask;
`else
  assign any = 1'b1;
  assign first = 3'd0;
  assign nxt = I + 3'd1;
  assign nxt_found = I != 3'd7;
`endif
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (start && !stop) state_d = any ? ACTIVE : DONE;
      ACTIVE:  state_d = stop ? IDLE : (cnt == '0 ? GAP : ACTIVE);
      GAP:     state_d = stop ? IDLE : (nxt_found ? ACTIVE : DONE);
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      En <= EN_OFF;
      I <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      cnt <= '0;
      dwell_q <= '0;
    end else begin
      state <= state_d;
      En <= state_d == ACTIVE ? EN_ON : EN_OFF;
      busy <= state_d == ACTIVE || state_d == GAP;
      done <= state_d == DONE;
      if (state == IDLE && state_d != IDLE) begin
        dwell_q <= dwell_m1;
        cnt <= dwell_m1;
        if (any) I <= first;
      end else if (state == GAP && state_d == ACTIVE) begin
        cnt <= dwell_q;
        I <= nxt;
      end else if (state == ACTIVE && cnt != '0) cnt <= cnt - DWELL_W'(1);
    end
  a_en_active: assert property (@(posedge clk) disable iff (rst) En == EN_ON |-> state == ACTIVE);
  a_i_stable: assert property (@(posedge clk) disable iff (rst) En == EN_ON |=> (En != EN_ON || $stable(I)));
endmodule
